// File: rtl/hi6110_pkg.sv
// Shared definitions for the HI-6110 host-side bus sequencers (read and write).
// Holds register address constants, the per-word frame timing defaults and
// the read sequencer state encoding.
package hi6110_pkg;

    // HI-6110 register addresses used by the host sequencers
    localparam logic [3:0] HI_ADDR_TX_STATUS = 4'b0000;
    localparam logic [3:0] HI_ADDR_RX_CMD    = 4'b0001;
    localparam logic [3:0] HI_ADDR_RX_DATA   = 4'b0010;
    localparam logic [3:0] HI_ADDR_CONTROL   = 4'b0100;

    // Frame shape of one word transfer, in clocks (tcnt runs 0..CYCLE_LEN-1)
    localparam int HI_CYCLE_LEN = 32;
    localparam int HI_CS_LO     = 5;
    localparam int HI_CS_HI     = 25;
    localparam int HI_STR_LO    = 10;
    localparam int HI_STR_HI    = 18;

    // Read sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_NEXT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/hi6110_bus_timer.sv
// Frame timer for one HI-6110 bus word: tcnt counter plus registered cs/str
// decode. tcnt counts while i_run is high and is held at 0 otherwise, so a
// frame always starts from tcnt=0. o_capture and o_frame_end are single-cycle
// pulses decoded from the current tcnt.
module hi6110_bus_timer
    import hi6110_pkg::*;
#(
    parameter int CYCLE_LEN = HI_CYCLE_LEN,
    parameter int CS_LO     = HI_CS_LO,
    parameter int CS_HI     = HI_CS_HI,
    parameter int STR_LO    = HI_STR_LO,
    parameter int STR_HI    = HI_STR_HI
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_run,
    output logic o_cs,
    output logic o_str,
    output logic o_capture,
    output logic o_frame_end
);

    localparam int TW = $clog2(CYCLE_LEN);
    localparam logic [TW-1:0] L_LAST   = TW'(CYCLE_LEN - 1);
    localparam logic [TW-1:0] L_CS_LO  = TW'(CS_LO);
    localparam logic [TW-1:0] L_CS_HI  = TW'(CS_HI);
    localparam logic [TW-1:0] L_STR_LO = TW'(STR_LO);
    localparam logic [TW-1:0] L_STR_HI = TW'(STR_HI);
    localparam logic [TW-1:0] L_CAP    = TW'(STR_HI + 1);
    localparam bit L_PARAMS_OK = (CS_LO < STR_LO) && (STR_LO <= STR_HI) &&
                                 (STR_HI < CS_HI) && (CS_HI < CYCLE_LEN - 1);

    logic [TW-1:0] r_tcnt;
    logic          r_cs;
    logic          r_str;
    logic          w_cs_win;
    logic          w_str_win;

    assign w_cs_win  = i_run && (r_tcnt >= L_CS_LO)  && (r_tcnt <= L_CS_HI);
    assign w_str_win = i_run && (r_tcnt >= L_STR_LO) && (r_tcnt <= L_STR_HI);

    // Frame counter: counts 0..CYCLE_LEN-1 while running, parked at 0 otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= '0;
        end else if (!i_run || (r_tcnt == L_LAST)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Registered active-low pin decode, one clock behind the tcnt window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cs  <= 1'b1;
            r_str <= 1'b1;
        end else begin
            r_cs  <= ~w_cs_win;
            r_str <= ~w_str_win;
        end
    end

    assign o_cs        = r_cs;
    assign o_str       = r_str;
    assign o_capture   = i_run && (r_tcnt == L_CAP);
    assign o_frame_end = i_run && (r_tcnt == L_LAST);

    // Window ordering must leave str nested inside cs and a quiet tail before the frame end
    a_params_legal: assert property (@(posedge clk) L_PARAMS_OK);

endmodule

// File: rtl/hi6110_reg_reader.sv
// HI-6110 register read sequencer. Accepts a burst request, runs one bus
// frame per word (CYCLE_LEN clocks plus one bookkeeping clock) and returns
// each captured word on rd_valid/rd_data, with rd_done after the last word.
// Handshake: rd_req is sampled only in IDLE; a request seen while busy is
// dropped. rd_valid and rd_done are single-cycle pulses with no back-pressure.
// Optional feature macro: HI6110_RD_VERIFY_EN reads every word twice at the
// same address and adds the rd_mismatch output.
module hi6110_reg_reader
    import hi6110_pkg::*;
#(
    parameter int CYCLE_LEN = HI_CYCLE_LEN,
    parameter int CS_LO     = HI_CS_LO,
    parameter int CS_HI     = HI_CS_HI,
    parameter int STR_LO    = HI_STR_LO,
    parameter int STR_HI    = HI_STR_HI,
    parameter int ADDR_INC  = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rd_req,
    input  logic [3:0]  rd_addr,
    input  logic [3:0]  rd_len,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_done,
    output logic [3:0]  reg_addr,
    inout  wire  [15:0] reg_data,
    output logic        cs,
    output logic        rw,
    output logic        str
`ifdef HI6110_RD_VERIFY_EN
    ,
    output logic        rd_mismatch
`endif
);

    rd_state_t   r_state;
    rd_state_t   w_next;
    logic [4:0]  r_cnt;
    logic [3:0]  r_addr;
    logic        r_busy;
    logic        r_valid;
    logic        r_done;
    logic [15:0] r_data;

    logic        w_run;
    logic        w_cs;
    logic        w_str;
    logic        w_capture;
    logic        w_frame_end;
    logic        w_accept;
    logic        w_done;
    logic        w_advance;
    logic        w_final;
    logic        w_repeat;
    logic [4:0]  w_len;

    assign w_run     = (r_state == ST_XFER);
    assign w_accept  = (r_state == ST_IDLE) && rd_req;
    assign w_len     = (rd_len == 4'd0) ? 5'd16 : {1'b0, rd_len};
    assign w_done    = (r_state == ST_NEXT) && (r_cnt == 5'd0);
    assign w_advance = (r_state == ST_NEXT) && (r_cnt != 5'd0) && !w_repeat;

    hi6110_bus_timer #(
        .CYCLE_LEN (CYCLE_LEN),
        .CS_LO     (CS_LO),
        .CS_HI     (CS_HI),
        .STR_LO    (STR_LO),
        .STR_HI    (STR_HI)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .i_run       (w_run),
        .o_cs        (w_cs),
        .o_str       (w_str),
        .o_capture   (w_capture),
        .o_frame_end (w_frame_end)
    );

`ifdef HI6110_RD_VERIFY_EN
    logic        r_pass2;
    logic [15:0] r_first;
    logic        r_mismatch;

    // Pass tracker: low during a word's first frame, high during its second
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pass2 <= 1'b0;
        end else if (w_frame_end) begin
            r_pass2 <= ~r_pass2;
        end
    end

    // Hold the first sample and compare it against the second at capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_first    <= '0;
            r_mismatch <= 1'b0;
        end else if (w_capture) begin
            if (!r_pass2) begin
                r_first <= reg_data;
            end else begin
                r_mismatch <= (reg_data != r_first);
            end
        end
    end

    // Second frame delivers the word; NEXT after the first frame repeats the address
    assign w_final     = r_pass2;
    assign w_repeat    = r_pass2;
    assign rd_mismatch = r_mismatch;
`else
    assign w_final  = 1'b1;
    assign w_repeat = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one XFER frame per bus read, one NEXT clock between frames
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (rd_req)      w_next = ST_XFER;
            ST_XFER: if (w_frame_end) w_next = ST_NEXT;
            ST_NEXT: w_next = (r_cnt == 5'd0) ? ST_IDLE : ST_XFER;
            default: w_next = ST_IDLE;
        endcase
    end

    // Remaining word count: loaded on accept, decremented when a word's last frame ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_len;
        end else if (w_frame_end && w_final) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Register address: changes only on accept or between words, while cs is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= rd_addr;
        end else if (w_advance && (ADDR_INC != 0)) begin
            r_addr <= r_addr + 4'd1;
        end
    end

    // Busy flag from accept through the last word's bookkeeping clock
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end
    end

    // Word capture on the edge where str returns high, with a one-cycle valid pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_capture && w_final;
            if (w_capture && w_final) begin
                r_data <= reg_data;
            end
        end
    end

    // Burst completion pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done;
        end
    end

    assign rd_busy  = r_busy;
    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_done  = r_done;
    assign reg_addr = r_addr;
    assign cs       = w_cs;
    assign str      = w_str;
    assign rw       = 1'b1;
    assign reg_data = 16'bz;

endmodule

// File: tb/tb_hi6110_reg_reader.sv
// Testbench for hi6110_reg_reader. Two instances (ADDR_INC=0 and ADDR_INC=1)
// share one HI-6110 bus model; sel chooses which one is exercised.
// Supports the HI6110_RD_VERIFY_EN build as well as the default build.
module tb_hi6110_reg_reader;
    import hi6110_pkg::*;

`ifdef HI6110_RD_VERIFY_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif
    localparam int FRAME   = HI_CYCLE_LEN + 1;
    localparam int WORD    = P * FRAME;
    localparam int CAP     = HI_STR_HI + 2;
    localparam int CS_LEN  = HI_CS_HI - HI_CS_LO + 1;
    localparam int STR_LEN = HI_STR_HI - HI_STR_LO + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstn;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_len;
    logic        sel;
    wire  [15:0] reg_data;
    logic [15:0] bus_val;
    logic        bus_en;

    logic [1:0]  busy_v, valid_v, done_v, cs_v, rw_v, str_v, req_v;
    logic [15:0] data_v [2];
    logic [3:0]  addr_v [2];

    logic        m_busy, m_valid, m_done, m_cs, m_rw, m_str;
    logic [15:0] m_data;
    logic [3:0]  m_addr;

    assign req_v[0] = rd_req & ~sel;
    assign req_v[1] = rd_req & sel;
    assign m_busy  = busy_v[sel];
    assign m_valid = valid_v[sel];
    assign m_done  = done_v[sel];
    assign m_cs    = cs_v[sel];
    assign m_rw    = rw_v[sel];
    assign m_str   = str_v[sel];
    assign m_data  = data_v[sel];
    assign m_addr  = addr_v[sel];

`ifdef HI6110_RD_VERIFY_EN
    logic [1:0] mism_v;
    logic       m_mism;
    assign m_mism = mism_v[sel];
`endif

    hi6110_reg_reader #(.ADDR_INC(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .rd_req(req_v[0]), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_busy(busy_v[0]), .rd_valid(valid_v[0]), .rd_data(data_v[0]), .rd_done(done_v[0]),
        .reg_addr(addr_v[0]), .reg_data(reg_data), .cs(cs_v[0]), .rw(rw_v[0]), .str(str_v[0])
`ifdef HI6110_RD_VERIFY_EN
        , .rd_mismatch(mism_v[0])
`endif
    );

    hi6110_reg_reader #(.ADDR_INC(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .rd_req(req_v[1]), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_busy(busy_v[1]), .rd_valid(valid_v[1]), .rd_data(data_v[1]), .rd_done(done_v[1]),
        .reg_addr(addr_v[1]), .reg_data(reg_data), .cs(cs_v[1]), .rw(rw_v[1]), .str(str_v[1])
`ifdef HI6110_RD_VERIFY_EN
        , .rd_mismatch(mism_v[1])
`endif
    );

    // HI-6110 bus model: drives a fresh word for every read frame
    logic [15:0] pre_q [$];
    logic [15:0] drv_q [$];
    logic [3:0]  fa_q  [$];
    assign bus_en   = (m_cs == 1'b0) && (m_rw == 1'b1);
    assign reg_data = bus_en ? bus_val : 16'bz;

    always @(negedge m_cs) begin
        if (rstn) begin
            if (pre_q.size() > 0) bus_val = pre_q.pop_front();
            else                  bus_val = 16'($urandom);
            drv_q.push_back(bus_val);
            fa_q.push_back(m_addr);
        end
    end

    // output monitor, sampled on the falling edge
    logic [15:0] val_q [$];
    int          vcyc_q [$];
    int          dcyc_q [$];
    int          cs_runs_q [$];
    int          str_runs_q [$];
    logic        mm_q [$];
    int          busy_cnt = 0;
    int          rw_bad = 0;
    int          cs_run = 0;
    int          str_run = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            val_q.push_back(m_data);
            vcyc_q.push_back(cyc);
`ifdef HI6110_RD_VERIFY_EN
            mm_q.push_back(m_mism);
`endif
        end
        if (m_done) dcyc_q.push_back(cyc);
        if (m_busy) busy_cnt++;
        if (m_rw !== 1'b1) rw_bad++;
        if (!m_cs) cs_run++;
        else if (cs_run != 0) begin cs_runs_q.push_back(cs_run); cs_run = 0; end
        if (!m_str) str_run++;
        else if (str_run != 0) begin str_runs_q.push_back(str_run); str_run = 0; end
    end

    // scoreboard counters and the single comparison point
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst against the selected instance, checked against the reference model
    task automatic do_read(input logic s, input logic [3:0] a, input logic [3:0] l, input int poke_at);
        int n;
        int ca;
        int t;
        logic [3:0] ea;
        sel = s;
        val_q.delete(); vcyc_q.delete(); dcyc_q.delete(); drv_q.delete(); fa_q.delete();
        cs_runs_q.delete(); str_runs_q.delete(); mm_q.delete();
        busy_cnt = 0;
        @(negedge clk);
        rd_addr = a; rd_len = l; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        ca = cyc;
        n = (l == 4'd0) ? 16 : int'(l);
        t = 0;
        while (dcyc_q.size() == 0 && t < n * WORD + 100) begin
            if (t == poke_at) begin
                rd_req = 1'b1; rd_addr = 4'($urandom); rd_len = 4'($urandom);
            end else begin
                rd_req = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        rd_req = 1'b0;
        repeat (40) @(negedge clk);

        chk("done_count", dcyc_q.size(), 1);
        if (dcyc_q.size() > 0) chk("done_cycle", dcyc_q[0] - ca, n * WORD);
        chk("busy_cycles", busy_cnt, n * WORD);
        chk("valid_count", val_q.size(), n);
        chk("frame_count", drv_q.size(), n * P);
        chk("cs_frames", cs_runs_q.size(), n * P);
        chk("str_frames", str_runs_q.size(), n * P);
        for (int k = 0; k < n; k++) begin
            ea = s ? 4'(int'(a) + k) : a;
            if (k < vcyc_q.size()) begin
                chk("valid_cycle", vcyc_q[k] - ca, (P - 1) * FRAME + CAP + k * WORD);
                if (k * P + P - 1 < drv_q.size()) chk("rd_data", val_q[k], drv_q[k * P + P - 1]);
`ifdef HI6110_RD_VERIFY_EN
                if (k * 2 + 1 < drv_q.size() && k < mm_q.size())
                    chk("rd_mismatch", mm_q[k], drv_q[k * 2] != drv_q[k * 2 + 1]);
`endif
            end
            for (int j = 0; j < P; j++)
                if (k * P + j < fa_q.size()) chk("frame_addr", fa_q[k * P + j], ea);
        end
        foreach (cs_runs_q[i])  chk("cs_low_len", cs_runs_q[i], CS_LEN);
        foreach (str_runs_q[i]) chk("str_low_len", str_runs_q[i], STR_LEN);
        chk("rw_high", rw_bad, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rs;
        logic [3:0] ra;
        logic [3:0] rl;
        int         ca;
        rstn = 1'b0; rd_req = 1'b0; rd_addr = 4'h0; rd_len = 4'h0; sel = 1'b0; bus_val = 16'h0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_cs", m_cs, 1'b1);
        chk("rst_rw", m_rw, 1'b1);
        chk("rst_str", m_str, 1'b1);
        chk("rst_reg_addr", m_addr, 4'h0);
        chk("rst_rd_data", m_data, 16'h0);
        chk("rst_rd_valid", m_valid, 1'b0);
        chk("rst_rd_done", m_done, 1'b0);
        chk("rst_rd_busy", m_busy, 1'b0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // single read at 4'h4 returning 16'h1028
        for (int i = 0; i < P; i++) pre_q.push_back(16'h1028);
        do_read(1'b0, 4'h4, 4'd1, -1);
        chk("single_data_1028", (val_q.size() > 0) ? val_q[0] : 16'h0, 16'h1028);

        // burst of 3 with address increment across the wrap
        do_read(1'b1, 4'hE, 4'd3, -1);

        // rd_len=0 means 16 words, constant address
        do_read(1'b0, 4'($urandom), 4'd0, -1);

        // request during an active burst is dropped
        do_read(1'b1, 4'h9, 4'd4, 40);

        // random bursts on either instance
        for (int r = 0; r < 4; r++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 4'($urandom);
            rl = 4'($urandom_range(1, 5));
            do_read(rs, ra, rl, -1);
        end

        // reset dropped at tcnt=12 of word 2
        sel = 1'b0;
        val_q.delete(); dcyc_q.delete();
        @(negedge clk);
        rd_addr = 4'h7; rd_len = 4'd3; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        ca = cyc;
        repeat (WORD + 12) @(negedge clk);
        chk("pre_rst_cycle", cyc - ca, WORD + 12);
        chk("pre_rst_cs_low", m_cs, 1'b0);
        chk("pre_rst_str_low", m_str, 1'b0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_cs", m_cs, 1'b1);
        chk("mid_rst_str", m_str, 1'b1);
        chk("mid_rst_rw", m_rw, 1'b1);
        chk("mid_rst_busy", m_busy, 1'b0);
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_done", m_done, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_valid_count", val_q.size(), 1);
        chk("rst_done_count", dcyc_q.size(), 0);
        do_read(1'b0, 4'h3, 4'd2, -1);

`ifdef HI6110_RD_VERIFY_EN
        // differing then stable samples
        pre_q.push_back(16'hAAAA); pre_q.push_back(16'hAAAB);
        pre_q.push_back(16'h5555); pre_q.push_back(16'h5555);
        do_read(1'b0, 4'h2, 4'd2, -1);
        chk("verify_data", (val_q.size() > 0) ? val_q[0] : 16'h0, 16'hAAAB);
        chk("verify_mism1", (mm_q.size() > 0) ? mm_q[0] : 1'b0, 1'b1);
        chk("verify_mism0", (mm_q.size() > 1) ? mm_q[1] : 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hi6110_reg_reader.md
Name: hi6110_reg_reader

Overview:
- Host-side register read sequencer for the HI-6110 1553B remote terminal.
- Issues one or more read cycles on the HI-6110 parallel bus (reg_addr, reg_data, cs, rw, str) and returns captured 16-bit words on a valid-strobe interface.
- Fetches received command/data words and status after the RT has been configured by the register write sequencer.
- Bus timing per word uses the same 32-clock frame shape as the write path.

Parameters:
- CYCLE_LEN, 32, clocks per word transfer; tcnt runs 0..CYCLE_LEN-1.
- CS_LO, 5, first tcnt value with cs asserted.
- CS_HI, 25, last tcnt value with cs asserted.
- STR_LO, 10, first tcnt value with str asserted.
- STR_HI, 18, last tcnt value with str asserted.
- ADDR_INC, 0, 0 = same address for every burst word; 1 = address increments per word, wrapping 4'hF to 4'h0.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rd_req  in  1  start request; sampled only in IDLE
- rd_addr  in  4  first register address, latched on accept
- rd_len  in  4  burst length in words; 0 means 16
- rd_busy  out  1  high from accept through the last word's GAP
- rd_valid  out  1  one-cycle pulse when rd_data holds a new word
- rd_data  out  16  captured word
- rd_done  out  1  one-cycle pulse after the final word of a burst
- reg_addr  out  4  HI-6110 register address
- reg_data  inout  16  HI-6110 data bus; this block never drives it
- cs  out  1  chip select, active low
- rw  out  1  read/write select, 1 = read
- str  out  1  strobe, active low

Behaviour:
- Reset: cs=1, rw=1, str=1, reg_addr=0, rd_data=0, rd_valid=0, rd_done=0, rd_busy=0, FSM=IDLE, tcnt=0.
- reg_data is high-Z at all times, including during reset.
- rw is held at 1 whenever out of reset.
- FSM states:
  - IDLE
  - XFER: tcnt counting
  - NEXT: one cycle for word bookkeeping
- IDLE to XFER on rd_req=1:
  - Latch rd_addr into reg_addr.
  - Latch the word count: rd_len, with 0 mapped to 16, held in a 5-bit counter.
  - rd_busy rises on the next cycle; tcnt=0 on the first XFER cycle.
- rd_req while rd_busy=1 is ignored (no queueing).
- cs and str are registered decodes of tcnt, so each pin changes one clock after tcnt enters or leaves its window:
  - cs=0 for tcnt in [CS_LO, CS_HI].
  - str=0 for tcnt in [STR_LO, STR_HI].
- Capture:
  - On the edge where tcnt==STR_HI+1, reg_data is registered into rd_data; this is the same edge on which the str pin returns high.
  - rd_valid pulses on the following cycle.
- At tcnt==CYCLE_LEN-1, go to NEXT and decrement the word count.
  - If the count becomes 0: pulse rd_done, drop rd_busy, return to IDLE.
  - Otherwise, if ADDR_INC=1, reg_addr advances (4-bit wrap); re-enter XFER with tcnt=0.
- reg_addr is stable for the whole frame; it changes only in IDLE-accept or NEXT, with cs high.
- Words are back-to-back at CYCLE_LEN+1 clocks each. A single-word read takes CYCLE_LEN+1 clocks from accept to rd_done.
- Reset asserted mid-burst: all outputs immediately go to reset values, the partial word is discarded, no rd_valid or rd_done is produced.
- Parameter legality, checked by simulation assertion: CS_LO < STR_LO <= STR_HI < CS_HI < CYCLE_LEN-1.

Optional Feature:
- Macro: HI6110_RD_VERIFY_EN.
- When defined:
  - Each word is read twice in consecutive frames at the same address.
  - rd_valid fires only after the second capture; rd_data is the second sample.
  - Added output rd_mismatch (1 bit) is valid alongside rd_valid and is 1 if the two samples differ.
  - Per-word time becomes 2*(CYCLE_LEN+1).
- When not defined: single read per word, and port rd_mismatch is absent.

Decomposition:
- Shared package hi6110_pkg holds:
  - register address constants (transmit status word 4'b0000, control register 4'b0100, receive buffer addresses);
  - timing defaults CYCLE_LEN/CS_LO/CS_HI/STR_LO/STR_HI, shared with the write sequencer;
  - the FSM state typedef.
- Natural sub-module: hi6110_bus_timer (tcnt counter plus registered cs/str decode, start/frame_end/capture pulses). The write sequencer can later reuse it.

Test Plan:
- Single read at address 4'h4, bus model returns 16'h1028 during str low -> cs low 21 clocks, str low 9 clocks, rw=1 throughout, rd_valid once with rd_data=16'h1028, rd_done 33 clocks after accept, reg_data never driven by the DUT.
- Burst rd_len=3 at 4'hE with ADDR_INC=1 -> reg_addr sequence E, F, 0; three rd_valid pulses 33 clocks apart; one rd_done.
- rd_len=0 with ADDR_INC=0 -> exactly 16 words read, address constant, rd_busy high for 16*33 clocks.
- rd_req pulsed during an active burst -> ignored; word count and addresses unchanged; no extra frame.
- rstn dropped at tcnt=12 of word 2 -> cs/str/rw=1 asynchronously, rd_busy=0, no rd_valid or rd_done; a new request after release starts cleanly.
- With HI6110_RD_VERIFY_EN, model returns 16'hAAAA then 16'hAAAB -> rd_valid with rd_data=16'hAAAB and rd_mismatch=1; stable data gives rd_mismatch=0.
